// File: rtl/resistor_capacitor_low_pass_filter.sv
// rtl/resistor_capacitor_low_pass_filter.sv - first-order RC low-pass filter, serial multiplier
//
// Purpose: y[n] = y[n-1] + ((alpha * (x[n] - y[n-1])) >>> 16), with alpha an
// unsigned Q0.16 coefficient derived from R, C and the sample rate at
// elaboration, or taken from ALPHA_OVERRIDE when nonzero. One sample costs
// 18 clocks: LOAD, 16 shift-add steps in MUL, then ACC.
//
// Ports:
//   clk          - system clock, rising edge
//   reset_n      - asynchronous active-low reset
//   audio_clk_en - one-clk sample strobe; only honoured in IDLE
//   in           - signed 16-bit input sample
//   out          - signed 16-bit filtered sample, held between updates
//   out_valid    - one-cycle pulse after each out update
//   overrun      - sticky, set when a strobe arrives while busy
//
// Configuration macro:
//   RC_LPF_ROUNDING_EN - when defined, round half up before the >>> 16;
//                        otherwise truncate toward negative infinity.

module resistor_capacitor_low_pass_filter #(
  parameter int CLOCK_RATE     = 50000000,
  parameter int SAMPLE_RATE    = 48000,
  parameter int R              = 47000,
  parameter int C_35_SHIFTED   = 113387,
  parameter int ALPHA_OVERRIDE = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        audio_clk_en,
  input  logic [15:0] in,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        overrun
);

  // Time step and RC constant share a 2^32 scale so their ratio is unitless.
  localparam logic [63:0] DELTA_T_32 = (64'd1 << 32) / 64'(SAMPLE_RATE);
  localparam logic [63:0] RC_32      = (64'(R) * 64'(C_35_SHIFTED)) >> 3;
  localparam logic [63:0] ALPHA_CALC = (DELTA_T_32 << 16) / (RC_32 + DELTA_T_32);
  localparam logic [15:0] ALPHA      = (ALPHA_OVERRIDE != 0) ? 16'(ALPHA_OVERRIDE) :
                                       (ALPHA_CALC > 64'd65535) ? 16'hFFFF :
                                       ALPHA_CALC[15:0];

  // An 18-cycle computation must fit between strobes with margin.
  if (CLOCK_RATE / SAMPLE_RATE < 20) begin : g_rate_check
    $fatal(1, "CLOCK_RATE / SAMPLE_RATE must be at least 20");
  end

  typedef enum logic [1:0] {IDLE, LOAD, MUL, ACC} state_t;

  state_t             state, state_next;
  logic        [15:0] x_reg;
  logic        [16:0] diff;
  logic        [33:0] acc;
  logic        [3:0]  cnt;
  logic        [33:0] diff_ext;
  logic signed [34:0] acc_adj;
  logic signed [34:0] acc_shr;
  logic signed [34:0] sum_full;
  logic        [15:0] sat_out;

  assign diff_ext = {{17{diff[16]}}, diff};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (audio_clk_en) state_next = LOAD;
      LOAD:    state_next = MUL;
      MUL:     if (cnt == 4'd15) state_next = ACC;
      ACC:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Final sum is formed wide so saturation sees the true value.
  always_comb begin
    acc_adj = {acc[33], acc};
`ifdef RC_LPF_ROUNDING_EN
    acc_adj = acc_adj + 35'sd32768;
`endif
    acc_shr  = acc_adj >>> 16;
    sum_full = acc_shr + {{19{out[15]}}, out};
    if (sum_full > 35'sd32767) begin
      sat_out = 16'h7FFF;
    end else if (sum_full < -35'sd32768) begin
      sat_out = 16'h8000;
    end else begin
      sat_out = sum_full[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg     <= '0;
      diff      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      // Strobes outside IDLE are dropped; the sample in flight is unaffected.
      if (audio_clk_en && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (audio_clk_en) x_reg <= in;
        end
        LOAD: begin
          diff <= {x_reg[15], x_reg} - {out[15], out};
          acc  <= '0;
          cnt  <= '0;
        end
        MUL: begin
          // alpha is unsigned, so each set bit adds the sign-extended diff
          // weighted by its bit position.
          if (ALPHA[cnt]) acc <= acc + (diff_ext << cnt);
          cnt <= cnt + 4'd1;
        end
        ACC: begin
          out       <= sat_out;
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_resistor_capacitor_low_pass_filter.sv
// tb/tb_resistor_capacitor_low_pass_filter.sv - scoreboard bench for the RC low-pass filter

module tb_resistor_capacitor_low_pass_filter;

  typedef struct {
    int inst;
    int val;
    int cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in_s = '0;
  logic [2:0]  en = '0;
  logic [15:0] out_w [3];
  logic [2:0]  ov;
  logic [2:0]  orun;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   y_model [3];
  int   alpha_m [3];
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  resistor_capacitor_low_pass_filter u_dflt (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(en[0]), .in(in_s),
    .out(out_w[0]), .out_valid(ov[0]), .overrun(orun[0])
  );

  resistor_capacitor_low_pass_filter #(.ALPHA_OVERRIDE(32768)) u_half (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(en[1]), .in(in_s),
    .out(out_w[1]), .out_valid(ov[1]), .overrun(orun[1])
  );

  resistor_capacitor_low_pass_filter #(.ALPHA_OVERRIDE(65535)) u_full (
    .clk(clk), .reset_n(reset_n), .audio_clk_en(en[2]), .in(in_s),
    .out(out_w[2]), .out_valid(ov[2]), .overrun(orun[2])
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int model(input int y, input int x, input int a);
    longint p;
    int     r;
    p = longint'(a) * longint'(x - y);
`ifdef RC_LPF_ROUNDING_EN
    p = p + 64'sd32768;
`endif
    p = p >>> 16;
    r = y + int'(p);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  function automatic int out_of(input int i);
    return int'($signed(out_w[i]));
  endfunction

  // Strobe one instance; if a capture is expected, predict its result and
  // the edge on which it lands.
  task automatic drive(input int inst, input int v, input bit cap);
    exp_t e;
    @(negedge clk);
    in_s = 16'(v);
    en[inst] = 1'b1;
    if (cap) begin
      y_model[inst] = model(y_model[inst], v, alpha_m[inst]);
      e.inst = inst;
      e.val  = y_model[inst];
      e.cyc  = cyc + 1 + 18;
      sb.push_back(e);
    end
    @(negedge clk);
    en[inst] = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    sb.delete();
    for (int i = 0; i < 3; i++) y_model[i] = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (ov[i]) begin
        if (sb.size() == 0) begin
          check("spurious_valid", i, -1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_inst", i, e.inst);
          check("sb_out", out_of(i), e.val);
          check("sb_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int held;
    alpha_m[0] = 8;
    alpha_m[1] = 32768;
    alpha_m[2] = 65535;
    for (int i = 0; i < 3; i++) y_model[i] = 0;

    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_out", out_of(i), 0);
      check("rst_valid", int'(ov[i]), 0);
      check("rst_overrun", int'(orun[i]), 0);
    end
    reset_n = 1'b1;

    // Default coefficient: step of 16000 moves out by one LSB.
    drive(0, 16000, 1'b1);
    drain();
    check("dflt_step", out_of(0), 1);

    // Half coefficient, held input converges geometrically.
    drive(1, 1000, 1'b1);
    drain();
    check("half_1", out_of(1), 500);
    drive(1, 1000, 1'b1);
    drain();
    check("half_2", out_of(1), 750);
    drive(1, 1000, 1'b1);
    drain();
    check("half_3", out_of(1), 875);
    held = out_of(1);
    repeat (6) @(negedge clk);
    check("out_held", out_of(1), held);
    check("no_overrun", int'(orun[1]), 0);

    // Rounding boundary.
    do_reset();
    drive(1, 1, 1'b1);
    drain();
`ifdef RC_LPF_ROUNDING_EN
    check("round_1", out_of(1), 1);
`else
    check("round_1", out_of(1), 0);
`endif

    // Negative input, then full-scale swing without wrap.
    do_reset();
    drive(1, -1000, 1'b1);
    drain();
    check("neg_step", out_of(1), -500);
    drive(2, -32768, 1'b1);
    drain();
    drive(2, -32768, 1'b1);
    drain();
    check("full_neg", out_of(2), -32768);
    drive(2, 32767, 1'b1);
    drain();
    check("full_pos", out_of(2), 32766);

    // Strobe during MUL is dropped and flagged.
    do_reset();
    check("overrun_clr", int'(orun[1]), 0);
    drive(1, 1000, 1'b1);
    repeat (4) @(negedge clk);
    drive(1, 2000, 1'b0);
    check("overrun_mul", int'(orun[1]), 1);
    drain();
    check("overrun_result", out_of(1), 500);

    // Strobe on the ACC edge is an overrun, not a capture.
    do_reset();
    drive(1, 1000, 1'b1);
    repeat (16) @(negedge clk);
    drive(1, 3000, 1'b0);
    drain();
    repeat (25) @(negedge clk);
    check("acc_edge_overrun", int'(orun[1]), 1);
    check("acc_edge_out", out_of(1), 500);

    // Reset in the middle of a computation abandons it.
    drive(1, 1000, 1'b1);
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    void'(sb.pop_back());
    for (int i = 0; i < 3; i++) y_model[i] = 0;
    #1;
    check("midrst_out", out_of(1), 0);
    check("midrst_overrun", int'(orun[1]), 0);
    check("midrst_valid", int'(ov[1]), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_quiet", out_of(1), 0);
    drive(1, 1000, 1'b1);
    drain();
    check("midrst_next", out_of(1), 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/resistor_capacitor_low_pass_filter.md
RESISTOR_CAPACITOR_LOW_PASS_FILTER -- requirements
Module: resistor_capacitor_low_pass_filter

Interface
REQ-001 SHALL have parameter CLOCK_RATE, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter SAMPLE_RATE, default 48000, audio sample rate in Hz.
REQ-003 SHALL have parameter R, default 47000, resistance in ohms.
REQ-004 SHALL have parameter C_35_SHIFTED, default 113387, capacitance in farads multiplied by 2^35.
REQ-005 SHALL have parameter ALPHA_OVERRIDE, default 0; when nonzero, it is used directly as the 16-bit alpha.
REQ-006 SHALL have port clk, input, 1 bit, system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-008 SHALL have port audio_clk_en, input, 1 bit, sample strobe, one clk wide.
REQ-009 SHALL have port in, input, 16 bits, signed two's-complement sample.
REQ-010 SHALL have port out, output reg, 16 bits, signed filtered sample.
REQ-011 SHALL have port out_valid, output reg, 1 bit, one-cycle pulse on each out update.
REQ-012 SHALL have port overrun, output reg, 1 bit, sticky flag for a dropped strobe.

Function
REQ-013 SHALL compute alpha = (DELTA_T_32 << 16) / (RC_32 + DELTA_T_32) at elaboration, where:
- DELTA_T_32 = 2^32 / SAMPLE_RATE
- RC_32 = (R * C_35_SHIFTED) >> 3
- alpha is unsigned Q0.16, clamped to 65535.
- ALPHA_OVERRIDE, when nonzero, replaces this value.
REQ-014 SHALL implement y[n] = y[n-1] + ((alpha * (x[n] - y[n-1])) >>> 16), with y[-1] = 0.
REQ-015 SHALL use an FSM with states IDLE, LOAD, MUL, ACC.
REQ-016 SHALL behave as follows in IDLE:
- On an edge with audio_clk_en=1, capture in into x_reg and go to LOAD.
- Otherwise stay in IDLE.
REQ-017 SHALL, in LOAD, form the 17-bit signed diff = x_reg - out, clear the 34-bit accumulator and 4-bit counter, and go to MUL.
REQ-018 SHALL, in MUL, perform one serial shift-add step per cycle over the 16 alpha bits, LSB first; after the 16th step it goes to ACC.
REQ-019 SHALL, in ACC, load out with out + (acc >>> 16) saturated to [-32768, 32767], pulse out_valid for exactly one cycle, and return to IDLE.
REQ-020 SHALL update out exactly 18 rising edges after the capturing edge; out_valid is high during the cycle following that edge.
REQ-021 SHALL ignore audio_clk_en asserted in any state other than IDLE: x_reg is unchanged, overrun is set to 1, and the computation in flight completes normally.
REQ-022 SHALL treat an audio_clk_en coinciding with the ACC edge as an overrun, not as a capture.
REQ-023 SHALL fail elaboration when CLOCK_RATE / SAMPLE_RATE < 20.
REQ-024 SHALL hold out stable between updates; out_valid is 0 at all other times.
REQ-025 SHALL keep overrun set until reset.

Reset
REQ-026 SHALL, on reset_n=0, immediately force:
- state to IDLE;
- out, out_valid and overrun to 0;
- x_reg, accumulator and counter to 0.
REQ-027 SHALL abandon any in-flight computation on reset with no out_valid pulse; after reset_n rises, the first strobe is handled per REQ-016.

Configuration
REQ-028 SHALL use macro RC_LPF_ROUNDING_EN to select the rounding mode:
- Defined: add 32768 to acc before the >>> 16 in ACC (round half up).
- Undefined: truncate toward negative infinity (plain arithmetic shift).
- All other behaviour is identical either way.

Verification
REQ-029 SHALL test the default parameters: elaborated alpha = 8; a step of in = 16000 from reset gives out = 1 at the first update.
REQ-030 SHALL test ALPHA_OVERRIDE=32768, in=1000 held over 3 strobes: out = 500, 750, 875, each 18 cycles after its strobe with a single out_valid pulse.
REQ-031 SHALL test ALPHA_OVERRIDE=32768, in=1 from 0: out = 0 without RC_LPF_ROUNDING_EN, out = 1 with it.
REQ-032 SHALL test ALPHA_OVERRIDE=32768, in=-1000 from 0: out = -500; then in=32767 from out=-32768 with ALPHA_OVERRIDE=65535 gives out = 32766 with no wrap.
REQ-033 SHALL test a second strobe 5 cycles after a capture: it is ignored, overrun = 1, and the first result is still delivered at cycle 18.
REQ-034 SHALL test reset_n pulsed low during MUL: out = 0, overrun = 0, no out_valid, and the next strobe with in=1000 (alpha 32768) gives out = 500.
